// File: rtl/bkm_step_sequencer_pkg.sv
// Shared types for the BKM step sequencer: FSM states, mode encodings
// and the saturating helper used by the optional cycle counter.
package bkm_step_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef enum logic {
    MODE_E = 1'b0,
    MODE_L = 1'b1
  } bkm_mode_e;

  localparam int CC_W = 16;

  function automatic logic [CC_W-1:0] sat_inc(
    input logic [CC_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bkm_seq_counter.sv
// Iteration index n and step-latency counter lat_cnt with terminal flags.
// n stops at NITER-1 instead of wrapping so NITER == 2**LOG2N is legal.
module bkm_seq_counter #(
  parameter int LOG2N    = 6,
  parameter int NITER    = 64,
  parameter int STEP_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             start_i,
  input  logic             run_i,
  output logic [LOG2N-1:0] n_o,
  output logic             last_lat_o,
  output logic             last_iter_o
);

  localparam int LW = (STEP_LAT > 1) ? $clog2(STEP_LAT) : 1;
  localparam logic [LW-1:0]    LAT_LAST = LW'(STEP_LAT - 1);
  localparam logic [LOG2N-1:0] N_LAST   = LOG2N'(NITER - 1);

  logic [LW-1:0]    lat_q;
  logic [LOG2N-1:0] n_q;

  assign n_o         = n_q;
  assign last_lat_o  = (lat_q == LAT_LAST);
  assign last_iter_o = (n_q == N_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lat_q <= '0;
      n_q   <= '0;
    end else if (srst) begin
      lat_q <= '0;
      n_q   <= '0;
    end else if (enable) begin
      if (start_i) begin
        lat_q <= '0;
        n_q   <= '0;
      end else if (run_i) begin
        if (last_lat_o) begin
          lat_q <= '0;
          if (!last_iter_o) begin
            n_q <= n_q + 1'b1;
          end
        end else begin
          lat_q <= lat_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bkm_step_sequencer.sv
// Iteration controller for bkm_step: runs NITER steps per operand set.
// Optional BKM_SEQ_CYCLE_CNT_EN adds a saturating per-operation cycle counter.
module bkm_step_sequencer
  import bkm_step_sequencer_pkg::*;
#(
  parameter int WC       = 16,
  parameter int WD       = 64,
  parameter int LOG2N    = 6,
  parameter int NITER    = 64,
  parameter int STEP_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_format,
  input  logic [WD-1:0]    in_X0,
  input  logic [WD-1:0]    in_Y0,
  input  logic [WC-1:0]    in_u0,
  input  logic [WC-1:0]    in_v0,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [WD-1:0]    step_X_n,
  output logic [WD-1:0]    step_Y_n,
  output logic [WC-1:0]    step_u_n,
  output logic [WC-1:0]    step_v_n,
  input  logic [WD-1:0]    step_X_np1,
  input  logic [WD-1:0]    step_Y_np1,
  input  logic [WC-1:0]    step_u_np1,
  input  logic [WC-1:0]    step_v_np1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WD-1:0]    out_X,
  output logic [WD-1:0]    out_Y,
  output logic [WC-1:0]    out_u,
  output logic [WC-1:0]    out_v,
  output logic             busy,
  output logic [15:0]      cycle_cnt
);

  seq_state_e    state_q;
  logic [WD-1:0] x_q;
  logic [WD-1:0] y_q;
  logic [WC-1:0] u_q;
  logic [WC-1:0] v_q;
  logic          mode_q;
  logic [1:0]    fmt_q;
  logic          out_valid_q;

  logic accept;
  logic last_lat;
  logic last_iter;
  logic [LOG2N-1:0] n;

  assign in_ready = enable & (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != ST_IDLE);

  bkm_seq_counter #(
    .LOG2N   (LOG2N),
    .NITER   (NITER),
    .STEP_LAT(STEP_LAT)
  ) u_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .srst       (srst),
    .enable     (enable),
    .start_i    (accept),
    .run_i      (state_q == ST_RUN),
    .n_o        (n),
    .last_lat_o (last_lat),
    .last_iter_o(last_iter)
  );

  assign step_mode   = mode_q;
  assign step_format = fmt_q;
  assign step_n      = n;
  assign step_X_n    = x_q;
  assign step_Y_n    = y_q;
  assign step_u_n    = u_q;
  assign step_v_n    = v_q;

  // Operand regs double as result regs; out_* only qualified by out_valid.
  assign out_valid = out_valid_q;
  assign out_X     = x_q;
  assign out_Y     = y_q;
  assign out_u     = u_q;
  assign out_v     = v_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      mode_q      <= 1'b0;
      fmt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (srst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      mode_q      <= 1'b0;
      fmt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q     <= in_X0;
            y_q     <= in_Y0;
            u_q     <= in_u0;
            v_q     <= in_v0;
            mode_q  <= in_mode;
            fmt_q   <= in_format;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last_lat) begin
            x_q <= step_X_np1;
            y_q <= step_Y_np1;
            u_q <= step_u_np1;
            v_q <= step_v_np1;
            if (last_iter) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BKM_SEQ_CYCLE_CNT_EN
  logic [15:0] cc_q;

  // The handshake edge itself is not counted: the count covers the
  // run plus the cycles spent waiting on the consumer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cc_q <= '0;
    end else if (srst) begin
      cc_q <= '0;
    end else if (enable) begin
      if (accept) begin
        cc_q <= '0;
      end else if ((state_q == ST_RUN) ||
                   ((state_q == ST_DONE) && !out_ready)) begin
        cc_q <= sat_inc(cc_q);
      end
    end
  end

  assign cycle_cnt = cc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule
